hazard_ctrl: RTL and testbench

Hazard controller for the five-stage pipelined core. Consumes the register-address and control taps exported by the pipelined datapath and drives its stall, flush and forwarding-select inputs. It includes a post-reset flush sequencer so no stale state enters Execute after reset. It also keeps saturating hazard-event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: load-use stall, branch flush,
// operand forwarding, a post-reset flush sequencer and saturating event counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int CNT_WIDTH          = 32,
  parameter int RESET_FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardEE,
  input  logic                      cnt_clr,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [CNT_WIDTH-1:0]      fwd_cnt,
  output logic                      seq_busy
);

  typedef enum logic {RST_FLUSH, RUN} state_t;

  state_t               state_q, state_d;
  logic [3:0]           rfCnt_q, rfCnt_d;
  logic [CNT_WIDTH-1:0] stallCnt_q, flushCnt_q, fwdCnt_q;
  logic                 lwStall;
  logic [1:0]           fwdA, fwdB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST_FLUSH;
      rfCnt_q <= 4'(RESET_FLUSH_CYCLES - 1);
    end else begin
      state_q <= state_d;
      rfCnt_q <= rfCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rfCnt_d = rfCnt_q;
    if (state_q == RST_FLUSH) begin
      rfCnt_d = rfCnt_q - 4'd1;
      if (rfCnt_q == 4'd0) begin
        state_d = RUN;
        rfCnt_d = 4'd0;
      end
    end
  end

  // Memory-stage result is younger than Writeback, so it takes priority.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0))      fwdA = 2'b10;
    else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) fwdA = 2'b01;
    if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0))      fwdB = 2'b10;
    else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) fwdB = 2'b01;
    lwStall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  always_comb begin
    StallF    = 1'b1;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = 2'b00;
    ForwardEE = 2'b00;
    seq_busy  = 1'b1;
    if (state_q == RUN) begin
      StallF    = lwStall && !PCSrcE;
      StallD    = lwStall && !PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = lwStall || PCSrcE;
      ForwardAE = fwdA;
      ForwardEE = fwdB;
      seq_busy  = 1'b0;
    end
  end

  // Counters only move in RUN, stick at all-ones, and a clear beats any increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      fwdCnt_q   <= '0;
    end else if (cnt_clr) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      fwdCnt_q   <= '0;
    end else if (state_q == RUN) begin
      if (StallF && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + CNT_WIDTH'(1);
      if (PCSrcE && (flushCnt_q != '1))
        flushCnt_q <= flushCnt_q + CNT_WIDTH'(1);
      if (((ForwardAE != 2'b00) || (ForwardEE != 2'b00)) && (fwdCnt_q != '1))
        fwdCnt_q <= fwdCnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;
  assign fwd_cnt   = fwdCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes model expectations into a
// queue, and a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

  localparam int RAW     = 5;
  localparam int CW      = 4;
  localparam int RFC     = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [RAW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic           resSrc, pcSrc, rwM, rwW, clr;
  } stim_t;

  typedef struct {
    int stallF, stallD, flushD, flushE, fwdA, fwdB, busy;
    int sc, fc, wc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [RAW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic           ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, cnt_clr;
  logic           StallF, StallD, FlushD, FlushE, seq_busy;
  logic [1:0]     ForwardAE, ForwardEE;
  logic [CW-1:0]  stall_cnt, flush_cnt, fwd_cnt;

  exp_t expQ[$];
  int   vectors    = 0;
  int   miscompares = 0;

  bit   inReset;
  int   edgesSinceRelease;
  int   mStall, mFlush, mFwd;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW), .RESET_FLUSH_CYCLES(RFC)
  ) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardEE(ForwardEE),
    .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt),
    .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.rs1D = 0; s.rs2D = 0; s.rs1E = 0; s.rs2E = 0;
    s.rdE = 0; s.rdM = 0; s.rdW = 0;
    s.resSrc = 0; s.pcSrc = 0; s.rwM = 0; s.rwW = 0; s.clr = 0;
    return s;
  endfunction

  function automatic stim_t randStim(int clrOdds);
    stim_t s;
    s.rs1D = RAW'($urandom_range(0, 7)); s.rs2D = RAW'($urandom_range(0, 7));
    s.rs1E = RAW'($urandom_range(0, 7)); s.rs2E = RAW'($urandom_range(0, 7));
    s.rdE  = RAW'($urandom_range(0, 7)); s.rdM  = RAW'($urandom_range(0, 7));
    s.rdW  = RAW'($urandom_range(0, 7));
    s.resSrc = ($urandom_range(0, 2) == 0);
    s.pcSrc  = ($urandom_range(0, 4) == 0);
    s.rwM    = $urandom_range(0, 1) == 1;
    s.rwW    = $urandom_range(0, 1) == 1;
    s.clr    = (clrOdds > 0) && ($urandom_range(1, clrOdds) == 1);
    return s;
  endfunction

  // Which pipeline stage supplies an operand: 2 = Memory, 1 = Writeback, 0 = register file.
  function automatic int srcStage(int rs, stim_t s);
    if (rs == 0) return 0;
    if (s.rwM && int'(s.rdM) == rs) return 2;
    if (s.rwW && int'(s.rdW) == rs) return 1;
    return 0;
  endfunction

  function automatic exp_t modelOutputs(stim_t s);
    exp_t e;
    bit   loadUse;
    e.sc = mStall; e.fc = mFlush; e.wc = mFwd;
    e.busy = (inReset || edgesSinceRelease < RFC) ? 1 : 0;
    if (e.busy == 1) begin
      e.stallF = 1; e.stallD = 0; e.flushD = 1; e.flushE = 1;
      e.fwdA = 0; e.fwdB = 0;
    end else begin
      loadUse  = s.resSrc && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
      e.stallF = (loadUse && !s.pcSrc) ? 1 : 0;
      e.stallD = e.stallF;
      e.flushD = s.pcSrc ? 1 : 0;
      e.flushE = (loadUse || s.pcSrc) ? 1 : 0;
      e.fwdA   = srcStage(int'(s.rs1E), s);
      e.fwdB   = srcStage(int'(s.rs2E), s);
    end
    return e;
  endfunction

  function automatic int satInc(int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic modelEdge(stim_t s, exp_t e);
    if (inReset) return;
    if (s.clr) begin
      mStall = 0; mFlush = 0; mFwd = 0;
    end else if (e.busy == 0) begin
      if (e.stallF == 1) mStall = satInc(mStall);
      if (s.pcSrc) mFlush = satInc(mFlush);
      if (e.fwdA != 0 || e.fwdB != 0) mFwd = satInc(mFwd);
    end
    if (edgesSinceRelease < 1000) edgesSinceRelease++;
  endtask

  task automatic applyStimulus(stim_t s);
    exp_t e;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW;
    ResultSrcE0 = s.resSrc; PCSrcE = s.pcSrc;
    RegWriteM = s.rwM; RegWriteW = s.rwW; cnt_clr = s.clr;
    e = modelOutputs(s);
    expQ.push_back(e);
    @(posedge clk);
    modelEdge(s, e);
    #1;
  endtask

  task automatic enterReset();
    reset = 1'b0;
    inReset = 1;
    edgesSinceRelease = 0;
    mStall = 0; mFlush = 0; mFwd = 0;
  endtask

  task automatic releaseReset();
    reset = 1'b1;
    inReset = 0;
    edgesSinceRelease = 0;
  endtask

  task automatic checkField(string name, int act, int req);
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(exp_t e);
    vectors++;
    checkField("StallF",    int'(StallF),    e.stallF);
    checkField("StallD",    int'(StallD),    e.stallD);
    checkField("FlushD",    int'(FlushD),    e.flushD);
    checkField("FlushE",    int'(FlushE),    e.flushE);
    checkField("ForwardAE", int'(ForwardAE), e.fwdA);
    checkField("ForwardEE", int'(ForwardEE), e.fwdB);
    checkField("seq_busy",  int'(seq_busy),  e.busy);
    checkField("stall_cnt", int'(stall_cnt), e.sc);
    checkField("flush_cnt", int'(flush_cnt), e.fc);
    checkField("fwd_cnt",   int'(fwd_cnt),   e.wc);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    enterReset();
    applyStimulus(idle());
    @(posedge clk); #1;

    // Reset held for three cycles with live-looking taps, then the flush sequence.
    repeat (3) applyStimulus(randStim(0));
    releaseReset();
    repeat (4) applyStimulus(randStim(0));

    // Forwarding priority on both operands.
    s = idle(); s.rdM = 5; s.rwM = 1; s.rdW = 5; s.rwW = 1;
    s.rs1E = 5; applyStimulus(s);
    s.rwM = 0;  applyStimulus(s);
    s.rs1E = 0; applyStimulus(s);
    s.rwM = 1; s.rs2E = 5; applyStimulus(s);
    s.rwM = 0;  applyStimulus(s);
    s.rs2E = 0; applyStimulus(s);

    // Load-use stall, then the same with RdE = 0.
    s = idle(); s.clr = 1; applyStimulus(s);
    s = idle(); s.resSrc = 1; s.rdE = 7; s.rs2D = 7; applyStimulus(s);
    applyStimulus(idle());
    s.rdE = 0; applyStimulus(s);

    // Branch redirect alone, then together with a load-use hazard.
    s = idle(); s.pcSrc = 1; applyStimulus(s);
    applyStimulus(idle());
    s.resSrc = 1; s.rdE = 7; s.rs2D = 7; applyStimulus(s);
    applyStimulus(idle());

    // Saturation of the 4-bit counter, then a clear racing an active event.
    s = idle(); s.resSrc = 1; s.rdE = 7; s.rs2D = 7;
    repeat (20) applyStimulus(s);
    s.clr = 1; applyStimulus(s);
    applyStimulus(idle());

    // Reset asserted between edges while stall_cnt reads 9.
    s.clr = 0;
    repeat (9) applyStimulus(s);
    applyStimulus(idle());
    enterReset();
    applyStimulus(s);
    applyStimulus(s);
    releaseReset();
    repeat (3) applyStimulus(randStim(0));

    // Random traffic with occasional counter clears and one late reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        enterReset();
        applyStimulus(randStim(0));
        releaseReset();
      end
      applyStimulus(randStim(25));
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
